elastic_pipe: RTL and testbench
===============================

ELASTIC_PIPE -- requirements
Module: elastic_pipe

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, payload width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 The module SHALL have parameter RESET_VAL, default '0, WIDTH-bit value loaded into every stage's data register on reset.
REQ-004 clk  input  1  single clock; all state updates on posedge clk.
REQ-005 reset  input  1  synchronous, active-low reset (reset=0 resets on the next posedge clk).
REQ-006 flush  input  1  synchronous clear of all in-flight items.
REQ-007 in_valid  input  1  upstream item present.
REQ-008 in_ready  output  1  pipe accepts upstream item this cycle.
REQ-009 in_data  input  WIDTH  upstream payload.
REQ-010 out_valid  output  1  stage DEPTH-1 holds an item.
REQ-011 out_ready  input  1  downstream accepts item this cycle.
REQ-012 out_data  output  WIDTH  payload of stage DEPTH-1.
REQ-013 count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-014 Stage k (0..DEPTH-1) SHALL hold valid bit v[k] and data d[k]; out_valid=v[DEPTH-1], out_data=d[DEPTH-1].
REQ-015 Advance enable SHALL be adv[DEPTH]=out_ready, adv[k]=!v[k] | adv[k+1], combinational.
REQ-016 in_ready SHALL equal adv[0] & !flush.
REQ-017 Transfer SHALL occur only when valid & ready are both 1 on the same posedge (input and output sides independently).
REQ-018 When adv[k]=1 and flush=0: v[k] SHALL load v[k-1] (v[-1]=in_valid), and d[k] SHALL load d[k-1] (d[-1]=in_data) only if v[k-1]=1; otherwise d[k] holds.
REQ-019 When adv[k]=0 stage k SHALL hold v[k] and d[k].
REQ-020 Bubbles SHALL collapse: an item advances into an empty stage even while downstream stages are stalled.
REQ-021 Minimum latency SHALL be DEPTH cycles: item accepted at edge N is presented on out_valid after edge N+DEPTH-1 and can leave at edge N+DEPTH-1... i.e. out_valid rises DEPTH-1 cycles after the accepting edge, which equals DEPTH edges from in_valid assertion in an empty pipe.
REQ-022 Throughput SHALL be one item per cycle when out_ready=1 continuously.
REQ-023 Simultaneous output and input transfer with all stages full SHALL be allowed (in_ready=1 when out_ready=1).
REQ-024 flush=1 SHALL clear all v[k] at the next posedge, discard any in_data offered that cycle, and leave d[k] unchanged; an output transfer in the flush cycle still counts as completed by downstream.
REQ-025 count SHALL equal popcount(v) registered state, range 0..DEPTH, never wrapping.
REQ-026 out_data SHALL be stable while out_valid=1 and out_ready=0.

Reset
REQ-027 With reset=0 at a posedge, all v[k] SHALL become 0 and all d[k] SHALL become RESET_VAL.
REQ-028 After reset: out_valid=0, out_data=RESET_VAL, count=0, in_ready=1 (flush=0).
REQ-029 Reset SHALL take priority over flush and handshake; in-flight items during reset are dropped.

Structure
REQ-030 One sub-module elastic_pipe_stage (one valid bit + WIDTH data, inputs adv, flush, upstream v/d) SHALL be instantiated DEPTH times via generate.
REQ-031 No shared package types are required; count width SHALL be derived locally via $clog2(DEPTH+1).
REQ-032 No registered ready path; in_ready is a combinational function of v and out_ready.

Verification (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5)
REQ-033 reset=0 one cycle -> out_valid=0, out_data=8'hA5, count=0, in_ready=1.
REQ-034 out_ready=1, in_valid=1 with 8'h01..8'h10 on consecutive cycles -> out_data 8'h01..8'h10 on consecutive cycles, first out_valid 3 edges after first in_valid, no gaps.
REQ-035 out_ready=0, push 8'h11,8'h22,8'h33,8'h44 -> first three accepted, count=3, in_ready=0 on fourth; raise out_ready -> 8'h11 out, 8'h44 accepted the same edge.
REQ-036 Insert bubble: push 8'h55, idle 2 cycles, push 8'h66 with out_ready=0 -> items collapse to stages 2 and 1, count=2, order preserved.
REQ-037 Full pipe, flush=1 with in_valid=1, in_data=8'h77 -> next cycle count=0, out_valid=0, 8'h77 never emerges.
REQ-038 reset=0 asserted with count=2 and flush=1 -> next cycle count=0, out_data=8'hA5.

Source files
------------

// File: rtl/elastic_pipe_pkg.sv
// Shared helpers for the elastic pipeline.
// Holds the per-stage valid-bit update rule, which is used by every stage instance.
package elastic_pipe_pkg;

    // Flush wins over advance; a stalled stage keeps its valid bit.
    function automatic logic next_valid(
        input logic flush,
        input logic adv,
        input logic up_valid,
        input logic valid
    );
        if (flush)
            return 1'b0;
        else if (adv)
            return up_valid;
        else
            return valid;
    endfunction

endpackage

// File: rtl/elastic_pipe_stage.sv
// One register slot of the elastic pipeline: a valid bit plus payload.
// Payload loads only when a real item moves in, so an advancing bubble leaves stale data untouched.
module elastic_pipe_stage #(
    parameter int                WIDTH     = 8,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              adv,
    input  logic              up_valid,
    input  logic [WIDTH-1:0]  up_data,
    output logic              valid,
    output logic [WIDTH-1:0]  data
);
    import elastic_pipe_pkg::*;

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= RESET_VAL;
        end else begin
            valid <= next_valid(flush, adv, up_valid, valid);
            if (!flush && adv && up_valid)
                data <= up_data;
        end
    end

endmodule

// File: rtl/elastic_pipe.sv
// Elastic pipeline of DEPTH valid/ready register stages with bubble collapsing and flush.
// Ready is purely combinational: a stage may advance if it is empty or everything downstream advances.
module elastic_pipe #(
    parameter int                WIDTH     = 8,
    parameter int                DEPTH     = 2,
    parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [WIDTH-1:0]              out_data,
    output logic [$clog2(DEPTH+1)-1:0]    count
);
    localparam int CW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] v;
    logic [WIDTH-1:0] d [DEPTH];
    logic [DEPTH-1:0] up_v;
    logic [WIDTH-1:0] up_d [DEPTH];
    logic [DEPTH-1:0] adv;
    logic             chain;
    logic [CW-1:0]    occupied;

    // Walk from the output back to the input; a running OR avoids a self-referencing vector.
    always_comb begin
        adv   = '0;
        chain = out_ready;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            chain  = chain | !v[k];
            adv[k] = chain;
        end
    end

    generate
        for (genvar k = 0; k < DEPTH; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign up_v[k] = in_valid;
                assign up_d[k] = in_data;
            end else begin : g_body
                assign up_v[k] = v[k-1];
                assign up_d[k] = d[k-1];
            end

            elastic_pipe_stage #(
                .WIDTH     (WIDTH),
                .RESET_VAL (RESET_VAL)
            ) u_stage (
                .clk      (clk),
                .reset    (reset),
                .flush    (flush),
                .adv      (adv[k]),
                .up_valid (up_v[k]),
                .up_data  (up_d[k]),
                .valid    (v[k]),
                .data     (d[k])
            );
        end
    endgenerate

    always_comb begin
        occupied = '0;
        for (int k = 0; k < DEPTH; k++)
            occupied = occupied + CW'(v[k]);
    end

    assign in_ready  = adv[0] & !flush;
    assign out_valid = v[DEPTH-1];
    assign out_data  = d[DEPTH-1];
    assign count     = occupied;

endmodule

// File: tb/tb_elastic_pipe.sv
// Scoreboard bench for elastic_pipe (WIDTH=8, DEPTH=3, RESET_VAL=8'hA5).
// Directed vectors push expected payloads; a negedge monitor pops them on every output transfer.
module tb_elastic_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [1:0] count;

    logic [7:0] expq [$];
    int         nChecks = 0;
    int         nPassed = 0;

    elastic_pipe #(
        .WIDTH     (8),
        .DEPTH     (3),
        .RESET_VAL (8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
        in_valid  = iv;
        in_data   = id;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nChecks++;
        if (actual === expected)
            nPassed++;
        else
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    endtask

    // Any output transfer must match the oldest outstanding expected payload.
    always @(negedge clk) begin
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expq.size() == 0) begin
                nChecks++;
                $display("[TB] FAIL unexpected_output: got %0h expected none", out_data);
            end else begin
                checkOutput("out_data_order", {24'd0, out_data}, {24'd0, expq.pop_front()});
            end
        end
    end

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_out_data", {24'd0, out_data}, 32'hA5);
        checkOutput("reset_count", {30'd0, count}, 32'd0);
        checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
        reset = 1'b1;

        // Streaming at full rate: latency of three edges, then one item per cycle.
        for (int i = 1; i <= 16; i++) begin
            applyStimulus(1'b1, 8'(i), 1'b1, 1'b0);
            expq.push_back(8'(i));
            tick();
            if (i == 2)
                checkOutput("latency_not_early", {31'd0, out_valid}, 32'd0);
            if (i >= 3)
                checkOutput("stream_no_gap", {31'd0, out_valid}, 32'd1);
        end
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("stream_drained", {30'd0, count}, 32'd0);

        // Backpressure: three fill the pipe, the fourth enters alongside the first leaving.
        applyStimulus(1'b1, 8'h11, 1'b0, 1'b0);
        checkOutput("bp_ready_11", {31'd0, in_ready}, 32'd1);
        expq.push_back(8'h11);
        tick();
        applyStimulus(1'b1, 8'h22, 1'b0, 1'b0);
        checkOutput("bp_ready_22", {31'd0, in_ready}, 32'd1);
        expq.push_back(8'h22);
        tick();
        applyStimulus(1'b1, 8'h33, 1'b0, 1'b0);
        checkOutput("bp_ready_33", {31'd0, in_ready}, 32'd1);
        expq.push_back(8'h33);
        tick();
        checkOutput("bp_count_full", {30'd0, count}, 32'd3);
        applyStimulus(1'b1, 8'h44, 1'b0, 1'b0);
        checkOutput("bp_ready_full", {31'd0, in_ready}, 32'd0);
        tick();
        checkOutput("bp_count_held", {30'd0, count}, 32'd3);
        checkOutput("bp_data_stable", {24'd0, out_data}, 32'h11);
        applyStimulus(1'b1, 8'h44, 1'b1, 1'b0);
        checkOutput("bp_ready_passthru", {31'd0, in_ready}, 32'd1);
        expq.push_back(8'h44);
        tick();
        checkOutput("bp_count_swap", {30'd0, count}, 32'd3);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (3) tick();
        checkOutput("bp_drained", {30'd0, count}, 32'd0);

        // Bubble collapse: 55 and 66 end up adjacent at the output end while stalled.
        applyStimulus(1'b1, 8'h55, 1'b0, 1'b0);
        expq.push_back(8'h55);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) tick();
        applyStimulus(1'b1, 8'h66, 1'b0, 1'b0);
        expq.push_back(8'h66);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        tick();
        checkOutput("bubble_count", {30'd0, count}, 32'd2);
        checkOutput("bubble_head", {24'd0, out_data}, 32'h55);
        checkOutput("bubble_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        tick();
        checkOutput("bubble_adjacent", {31'd0, out_valid}, 32'd1);
        tick();
        checkOutput("bubble_drained", {30'd0, count}, 32'd0);

        // Flush of a full pipe drops everything, including the item offered that cycle.
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hA2, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hA3, 1'b0, 1'b0);
        tick();
        checkOutput("flush_pre_count", {30'd0, count}, 32'd3);
        applyStimulus(1'b1, 8'h77, 1'b0, 1'b1);
        checkOutput("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("flush_count", {30'd0, count}, 32'd0);
        checkOutput("flush_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("flush_data_kept", {24'd0, out_data}, 32'hA1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) tick();

        // Reset overrides flush and an offered item.
        applyStimulus(1'b1, 8'hB1, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hB2, 1'b0, 1'b0);
        tick();
        checkOutput("rst2_pre_count", {30'd0, count}, 32'd2);
        reset = 1'b0;
        applyStimulus(1'b1, 8'hC3, 1'b0, 1'b1);
        tick();
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0);
        checkOutput("rst2_count", {30'd0, count}, 32'd0);
        checkOutput("rst2_out_data", {24'd0, out_data}, 32'hA5);
        checkOutput("rst2_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst2_in_ready", {31'd0, in_ready}, 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) tick();

        checkOutput("scoreboard_empty", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", nPassed, nChecks);
        $finish;
    end

endmodule
